// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory
// between requesters A and B, with nibble-lane write masks.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   req_x, we_x      request (held until ack) and write select
//   addr_x, wdata_x  access address and write data
//   wmask_x          lane enables, [1]=upper half, [0]=lower half
//   ack_x, rdata_x   one-cycle completion pulse and read data
//   mem_*            strobe, write enable, address, data, lanes
//   mem_rdata        memory read data, valid the cycle after mem_en
module mem_port_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_a,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] wdata_a,
   input  logic [1:0]    wmask_a,
   output logic          ack_a,
   output logic [DW-1:0] rdata_a,
   input  logic          req_b,
   input  logic          we_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] wdata_b,
   input  logic [1:0]    wmask_b,
   output logic          ack_b,
   output logic [DW-1:0] rdata_b,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [1:0]    mem_wmask,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      COMPLETE
   } state_t;

   state_t        state_q;
   logic          last_b_q;
   logic          win_b_q;
   logic          rd_q;
   logic          ack_a_q;
   logic          ack_b_q;
   logic [DW-1:0] rdata_a_q;
   logic [DW-1:0] rdata_b_q;
   logic          mem_en_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [1:0]    mem_wmask_q;

   logic          gnt_a_d;
   logic          gnt_b_d;
   logic          sel_we_d;
   logic [AW-1:0] sel_addr_d;
   logic [DW-1:0] sel_wdata_d;
   logic [1:0]    sel_wmask_d;

   // On a tie the grant goes to whoever was not served last.
   always_comb begin
      gnt_a_d     = req_a & (~req_b | last_b_q);
      gnt_b_d     = req_b & (~req_a | ~last_b_q);
      sel_we_d    = gnt_b_d ? we_b    : we_a;
      sel_addr_d  = gnt_b_d ? addr_b  : addr_a;
      sel_wdata_d = gnt_b_d ? wdata_b : wdata_a;
      sel_wmask_d = gnt_b_d ? wmask_b : wmask_a;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_b_q    <= 1'b1;
         win_b_q     <= 1'b0;
         rd_q        <= 1'b0;
         ack_a_q     <= 1'b0;
         ack_b_q     <= 1'b0;
         rdata_a_q   <= '0;
         rdata_b_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= 2'b00;
      end else begin
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (gnt_a_d | gnt_b_d) begin
                  state_q     <= ISSUE;
                  win_b_q     <= gnt_b_d;
                  last_b_q    <= gnt_b_d;
                  rd_q        <= ~sel_we_d;
                  mem_en_q    <= 1'b1;
                  // An all-zero mask is a no-op write: no strobe.
                  mem_we_q    <= sel_we_d & (|sel_wmask_d);
                  mem_addr_q  <= sel_addr_d;
                  mem_wdata_q <= sel_wdata_d;
                  mem_wmask_q <= sel_we_d ? sel_wmask_d : 2'b00;
               end
            end
            ISSUE: begin
               state_q  <= COMPLETE;
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               ack_a_q  <= ~win_b_q;
               ack_b_q  <= win_b_q;
            end
            COMPLETE: begin
               state_q <= IDLE;
               if (rd_q && !win_b_q) rdata_a_q <= mem_rdata;
               if (rd_q && win_b_q)  rdata_b_q <= mem_rdata;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read data only exists at the memory during the ack cycle, so it
   // is forwarded then and held from the register afterwards.
   assign rdata_a = (ack_a_q & rd_q) ? mem_rdata : rdata_a_q;
   assign rdata_b = (ack_b_q & rd_q) ? mem_rdata : rdata_b_q;

   assign ack_a     = ack_a_q;
   assign ack_b     = ack_b_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model,
// directed scenarios and randomized traffic with random resets.
module tb_mem_port_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_a, we_a, ack_a;
   logic [7:0] addr_a, wdata_a, rdata_a;
   logic [1:0] wmask_a;
   logic       req_b, we_b, ack_b;
   logic [7:0] addr_b, wdata_b, rdata_b;
   logic [1:0] wmask_b;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0] mem_wmask;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(8), .DW(8)) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a),
      .wdata_a(wdata_a), .wmask_a(wmask_a),
      .ack_a(ack_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b),
      .wdata_b(wdata_b), .wmask_b(wmask_b),
      .ack_b(ack_b), .rdata_b(rdata_b),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata)
   );

   // Memory array stand-in: synchronous, lane-masked writes.
   logic [7:0] ram [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we && mem_wmask[1]) ram[mem_addr][7:4] <= mem_wdata[7:4];
         if (mem_we && mem_wmask[0]) ram[mem_addr][3:0] <= mem_wdata[3:0];
         mem_rdata <= ram[mem_addr];
      end
   end

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [1:0] mask;
   } txn_t;

   txn_t qa[$];
   txn_t qb[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: one access in flight at most.
   logic [7:0] mdl [256];
   int         cyc = 0;
   bit         pv = 0;
   int         pt = 0;
   int         free_at = 0;
   bit         pb = 0;
   txn_t       pk;
   logic [7:0] pexp = '0;
   bit         last_b = 1;
   logic [7:0] hold_a = '0, hold_b = '0;

   bit   keep = 0, gaps = 0, rst_at_issue = 0, want_zero = 0;
   int   ord[$];
   int   acyc[$];
   int   encyc[$];
   logic [7:0] last_rd_a = '0, last_rd_b = '0;
   bit   saw_we = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic check_zero();
      check("rst_ack_a", ack_a, 0);
      check("rst_ack_b", ack_b, 0);
      check("rst_rdata_a", rdata_a, 0);
      check("rst_rdata_b", rdata_b, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_wmask", mem_wmask, 0);
   endtask

   function automatic logic [7:0] merge(input logic [7:0] old,
                                        input txn_t t);
      logic [7:0] r;
      r = old;
      if (t.mask[1]) r[7:4] = t.wdata[7:4];
      if (t.mask[0]) r[3:0] = t.wdata[3:0];
      return r;
   endfunction

   // One cycle: called just after a falling edge.
   task automatic step(input bit rst_in);
      bit   is_iss, is_cmp, ack_ma, ack_mb, rst_now, go_b;
      txn_t t;
      if (want_zero) begin
         check_zero();
         want_zero = 0;
      end
      is_iss = pv && (cyc == pt + 1);
      is_cmp = pv && (cyc == pt + 2);
      ack_ma = is_cmp && !pb;
      ack_mb = is_cmp && pb;

      check("mem_en", mem_en, is_iss);
      if (is_iss) begin
         check("mem_we", mem_we, pk.we && (pk.mask != 2'b00));
         check("mem_addr", mem_addr, pk.addr);
         check("mem_wmask", mem_wmask, pk.we ? pk.mask : 2'b00);
         if (pk.we) check("mem_wdata", mem_wdata, pk.wdata);
         if (pk.we) mdl[pk.addr] = merge(mdl[pk.addr], pk);
      end else begin
         check("mem_we_idle", mem_we, 0);
      end
      check("ack_a", ack_a, ack_ma);
      check("ack_b", ack_b, ack_mb);
      if (ack_ma && !pk.we) hold_a = pexp;
      if (ack_mb && !pk.we) hold_b = pexp;
      check("rdata_a", rdata_a, hold_a);
      check("rdata_b", rdata_b, hold_b);
      if (is_cmp) pv = 0;

      if (mem_en) encyc.push_back(cyc);
      if (mem_we) saw_we = 1;
      if (ack_a) begin ord.push_back(0); acyc.push_back(cyc); last_rd_a = rdata_a; end
      if (ack_b) begin ord.push_back(1); acyc.push_back(cyc); last_rd_b = rdata_b; end

      // Requester agents hold req until the model says ack.
      if (ack_ma) begin
         if (keep && qa.size() > 0) begin
            t = qa.pop_front();
            {we_a, addr_a, wdata_a, wmask_a} = t;
         end else req_a = 0;
      end else if (!req_a && qa.size() > 0 &&
                   (!gaps || $urandom_range(0, 2) == 0)) begin
         t = qa.pop_front();
         {we_a, addr_a, wdata_a, wmask_a} = t;
         req_a = 1;
      end
      if (ack_mb) begin
         if (keep && qb.size() > 0) begin
            t = qb.pop_front();
            {we_b, addr_b, wdata_b, wmask_b} = t;
         end else req_b = 0;
      end else if (!req_b && qb.size() > 0 &&
                   (!gaps || $urandom_range(0, 2) == 0)) begin
         t = qb.pop_front();
         {we_b, addr_b, wdata_b, wmask_b} = t;
         req_b = 1;
      end

      rst_now = rst_in;
      if (rst_at_issue && is_iss) begin
         rst_now = 1;
         rst_at_issue = 0;
         want_zero = 1;
      end
      reset = rst_now;
      if (rst_now) begin
         pv = 0;
         last_b = 1;
         hold_a = '0;
         hold_b = '0;
         free_at = cyc + 1;
      end else if (!pv && cyc >= free_at && (req_a || req_b)) begin
         if (req_a && req_b) go_b = !last_b;
         else go_b = req_b;
         pk = go_b ? txn_t'{we_b, addr_b, wdata_b, wmask_b}
                   : txn_t'{we_a, addr_a, wdata_a, wmask_a};
         pb = go_b;
         last_b = go_b;
         pv = 1;
         pt = cyc;
         free_at = cyc + 3;
         pexp = mdl[pk.addr];
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() > 0 || qb.size() > 0 || req_a || req_b || pv)
             && n < 2000) begin
         step(0);
         n++;
      end
      if (n >= 2000) check("drain_timeout", 1, 0);
   endtask

   task automatic clear_logs();
      ord.delete();
      acyc.delete();
      encyc.delete();
      saw_we = 0;
   endtask

   function automatic txn_t rnd_txn();
      txn_t t;
      int   s;
      s = $urandom_range(0, 9);
      t.we    = $urandom_range(0, 1);
      t.addr  = (s == 0) ? 8'h00 : (s == 1) ? 8'hFF : 8'($urandom_range(0, 7));
      t.wdata = 8'($urandom);
      t.mask  = 2'($urandom);
      return t;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mdl[i] = '0;
         ram[i] = '0;
      end
      reset = 1;
      {req_a, we_a, addr_a, wdata_a, wmask_a} = '0;
      {req_b, we_b, addr_b, wdata_b, wmask_b} = '0;
      @(negedge clk);
      step(1);
      want_zero = 1;
      step(1);
      step(0);

      // Lane writes then readback.
      clear_logs();
      qa.push_back('{1'b1, 8'd3, 8'h90, 2'b10});
      qa.push_back('{1'b1, 8'd3, 8'h02, 2'b01});
      qa.push_back('{1'b0, 8'd3, 8'h00, 2'b00});
      drain();
      check("lane_rd", last_rd_a, 8'h92);
      check("lane_acks", ord.size(), 3);

      // Simultaneous requests straight out of reset.
      step(1);
      clear_logs();
      qa.push_back('{1'b1, 8'd4, 8'h07, 2'b11});
      qb.push_back('{1'b0, 8'd4, 8'h00, 2'b00});
      drain();
      check("tie_n", ord.size(), 2);
      if (ord.size() == 2) begin
         check("tie_first", ord[0], 0);
         check("tie_second", ord[1], 1);
         check("tie_gap", acyc[1] - acyc[0], 3);
      end
      check("tie_rd_b", last_rd_b, 8'h07);

      // Continuous contention alternates grants.
      clear_logs();
      keep = 1;
      for (int i = 0; i < 3; i++) begin
         qa.push_back('{1'b0, 8'd3, 8'h00, 2'b00});
         qb.push_back('{1'b0, 8'd4, 8'h00, 2'b00});
      end
      drain();
      keep = 0;
      check("rr_n", ord.size(), 6);
      for (int i = 0; i < 6 && i < ord.size(); i++)
         check($sformatf("rr_order%0d", i), ord[i], i % 2);
      for (int i = 1; i < encyc.size(); i++)
         check($sformatf("rr_en_gap%0d", i), encyc[i] - encyc[i-1], 3);

      // Mask-00 write is acked but never strobes the write enable.
      clear_logs();
      qa.push_back('{1'b1, 8'd3, 8'hFF, 2'b00});
      drain();
      check("nomask_we", saw_we, 0);
      check("nomask_ack", ord.size(), 1);
      qa.push_back('{1'b0, 8'd3, 8'h00, 2'b00});
      drain();
      check("nomask_rd", last_rd_a, 8'h92);

      // Address extremes.
      qb.push_back('{1'b1, 8'h00, 8'h42, 2'b11});
      qa.push_back('{1'b1, 8'hFF, 8'h99, 2'b11});
      drain();
      qb.push_back('{1'b0, 8'hFF, 8'h00, 2'b00});
      qa.push_back('{1'b0, 8'h00, 8'h00, 2'b00});
      drain();
      check("addr00_rd", last_rd_a, 8'h42);
      check("addrFF_rd", last_rd_b, 8'h99);

      // Reset lands on the issue cycle of a write.
      clear_logs();
      rst_at_issue = 1;
      qa.push_back('{1'b1, 8'd3, 8'h33, 2'b11});
      step(0);
      step(0);
      step(0);
      check("rst_iss_ram", ram[3], 8'h33);
      check("rst_iss_noack", ord.size(), 0);
      drain();
      check("rst_iss_retry", ord.size(), 1);
      qa.push_back('{1'b0, 8'd3, 8'h00, 2'b00});
      drain();
      check("rst_iss_rd", last_rd_a, 8'h33);

      // Randomized traffic with occasional resets.
      gaps = 1;
      for (int i = 0; i < 3000; i++) begin
         keep = $urandom_range(0, 1);
         if (qa.size() < 2) qa.push_back(rnd_txn());
         if (qb.size() < 2) qb.push_back(rnd_txn());
         step($urandom_range(0, 149) == 0);
      end
      drain();
      for (int i = 0; i < 256; i++)
         if (ram[i] !== mdl[i]) check($sformatf("ram%0d", i), ram[i], mdl[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 256x8 memory between two requesters, A and B.
- Arbitrates round-robin, sequences each access as an issue phase then a completion phase, and returns read data with an ack pulse.
- Supports nibble-granular writes, so a requester can update m[addr][7:4] or m[addr][3:0] independently.
- Sits between requester logic and the memory array, which is a separate block.

Parameters:
- AW, 8, address width (memory depth 2**AW).
- DW, 8, data width; must be even; mask lane = DW/2 bits.

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset.
- req_a  input  1  requester A access request; level, held until ack_a.
- we_a  input  1  A: 1=write, 0=read.
- addr_a  input  AW  A address.
- wdata_a  input  DW  A write data.
- wmask_a  input  2  A lane enables; [1]=upper half, [0]=lower half.
- ack_a  output  1  one-cycle pulse: A access complete.
- rdata_a  output  DW  A read data; valid when ack_a=1.
- req_b, we_b, addr_b, wdata_b, wmask_b, ack_b, rdata_b  same as A, for requester B.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_wmask  output  2  memory lane enables.
- mem_rdata  input  DW  memory read data, valid 1 cycle after mem_en.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=B, so A wins the first tie.
  - ack_a=ack_b=0, rdata_a=rdata_b=0.
  - mem_en=mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, COMPLETE.
- IDLE:
  - No req: stay in IDLE; mem_en=0.
  - One req: grant that requester.
  - Both req: grant the one not equal to last_grant.
  - On grant: latch the winner's we/addr/wdata/wmask, update last_grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1, mem_addr/mem_wdata/mem_wmask = latched values.
  - mem_we = latched we AND (wmask != 00).
  - A write with mask 00 is a no-op write but is still acked.
  - For reads, mem_we=0 and mem_wmask is don't-care (drive 00).
  - Next state COMPLETE.
- COMPLETE (exactly 1 cycle):
  - mem_en=mem_we=0.
  - Winner's ack pulses high for this cycle.
  - Winner's rdata = mem_rdata for a read, unchanged for a write.
  - Loser's ack stays 0 and its rdata is unchanged.
  - Next state IDLE.
- Latency: req sampled in IDLE cycle t; mem_en high in t+1; ack in t+2. Minimum 3 cycles per access, 1 access per 3 cycles per port pair.
- Requester handshake:
  - Fields must be stable in the IDLE cycle where req is sampled; later changes are ignored (latched).
  - A requester may drop req in the cycle after its ack.
  - req still high in the next IDLE cycle counts as a new request.
- Fairness: with both requesting continuously, grants alternate A,B,A,B...; neither waits more than one access.
- Lane write: the memory updates only lanes whose mask bit is 1. Upper lane = bits [DW-1:DW/2], lower lane = [DW/2-1:0].
- Reset mid-operation:
  - Reset in IDLE or COMPLETE: no memory access occurs; pending ack is suppressed.
  - Reset in ISSUE: the write presented that cycle commits at that edge (registered strobe already at the memory), but ack is suppressed. The requester must retry after reset if req is still high.
- Address wrap: no arithmetic on addresses; all 2**AW addresses are valid, including 0 and 255.
- No X propagation: mem_rdata is sampled only in COMPLETE for reads.

Test Plan:
- A writes addr 3 wdata 0x90 mask 10, then 0x02 mask 01; A reads addr 3 -> rdata_a=0x92; each ack arrives 2 cycles after req is sampled.
- req_a and req_b asserted together from reset, A writes addr 4=0x07, B reads addr 4 -> A is granted first; B is acked 3 cycles later with rdata_b=0x07; last_grant toggles.
- A and B both hold req for 6 accesses -> grant order A,B,A,B,A,B; mem_en high every third cycle.
- Write mask 00 to addr 3 (previously 0x92) with wdata 0xFF -> mem_we stays 0, ack is given, a readback returns 0x92.
- Addresses 0x00 and 0xFF written with 0x42/0x99 and read back -> 0x42/0x99; no aliasing.
- Reset asserted during the ISSUE cycle of a write 0x33 to addr 3 -> memory holds 0x33, no ack, all outputs are 0 the cycle after; the next request is served normally.
